// File: rtl/stream_config_queue_pkg.sv
// Shared register map, queue entry type and width helpers for the
// stream configuration queue.
package stream_config_pkg;

    localparam int unsigned REG_SELECT      = 0;
    localparam int unsigned REG_TYPE        = 1;
    localparam int unsigned REG_COMMIT      = 2;
    localparam int unsigned REG_STATUS      = 3;
    localparam int unsigned REGS_PER_STREAM = 4;

    // Entry fields are sized for the widest supported configuration; slots use the low bits.
    localparam int unsigned MAX_SELECT_WIDTH = 8;
    localparam int unsigned MAX_TYPE_WIDTH   = 16;

    typedef struct packed {
        logic [MAX_SELECT_WIDTH-1:0] sel;
        logic [MAX_TYPE_WIDTH-1:0]   typ;
    } entry_t;

    function automatic int unsigned calc_select_width(input int unsigned num_select);
        return (num_select <= 2) ? 1 : $clog2(num_select);
    endfunction

endpackage

// File: rtl/stream_config_queue_if.sv
// Host config bus plus the three per-stream ready/valid reconfiguration channels.
interface stream_config_queue_if #(
    parameter int unsigned NUM_STREAMS  = 2,
    parameter int unsigned SELECT_WIDTH = 2,
    parameter int unsigned TYPE_WIDTH   = 4,
    parameter int unsigned ADDR_WIDTH   = 8,
    parameter int unsigned DATA_WIDTH   = 32
);
    logic                                     cfg_wr_en;
    logic [ADDR_WIDTH-1:0]                    cfg_addr;
    logic [DATA_WIDTH-1:0]                    cfg_wr_data;
    logic                                     cfg_rd_en;
    logic [DATA_WIDTH-1:0]                    cfg_rd_data;

    logic [NUM_STREAMS-1:0]                   in_sel_valid;
    logic [NUM_STREAMS-1:0]                   in_sel_ready;
    logic [NUM_STREAMS-1:0][SELECT_WIDTH-1:0] in_sel_data;
    logic [NUM_STREAMS-1:0]                   out_sel_valid;
    logic [NUM_STREAMS-1:0]                   out_sel_ready;
    logic [NUM_STREAMS-1:0][SELECT_WIDTH-1:0] out_sel_data;
    logic [NUM_STREAMS-1:0]                   type_valid;
    logic [NUM_STREAMS-1:0]                   type_ready;
    logic [NUM_STREAMS-1:0][TYPE_WIDTH-1:0]   type_data;

    modport master (
        output cfg_wr_en, cfg_addr, cfg_wr_data, cfg_rd_en,
        input  cfg_rd_data,
        input  in_sel_valid, in_sel_data, out_sel_valid, out_sel_data, type_valid, type_data,
        output in_sel_ready, out_sel_ready, type_ready
    );

    modport slave (
        input  cfg_wr_en, cfg_addr, cfg_wr_data, cfg_rd_en,
        output cfg_rd_data,
        output in_sel_valid, in_sel_data, out_sel_valid, out_sel_data, type_valid, type_data,
        input  in_sel_ready, out_sel_ready, type_ready
    );

endinterface

// File: rtl/stream_config_queue_slot.sv
// One stream slot: shadow registers, DEPTH-deep entry queue and the
// three-channel atomic head handshake (ch 0 = in_select, 1 = out_select, 2 = type).
module stream_config_slot
    import stream_config_pkg::*;
#(
    parameter int unsigned SELECT_WIDTH = 2,
    parameter int unsigned TYPE_WIDTH   = 4,
    parameter int unsigned DEPTH        = 4,
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned LEVEL_WIDTH  = 3
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    wr_en,
    input  logic [1:0]              wr_offset,
    input  logic [DATA_WIDTH-1:0]   wr_data,
    output logic [SELECT_WIDTH-1:0] shadow_sel,
    output logic [TYPE_WIDTH-1:0]   shadow_typ,
    output logic [LEVEL_WIDTH-1:0]  level,
    output logic                    overflow,
    output logic [2:0]              ch_valid,
    input  logic [2:0]              ch_ready,
    output logic [SELECT_WIDTH-1:0] head_sel,
    output logic [TYPE_WIDTH-1:0]   head_typ
);
    localparam int unsigned PTR_WIDTH = (DEPTH <= 1) ? 1 : $clog2(DEPTH);

    entry_t                 mem [DEPTH];
    entry_t                 head;
    logic [PTR_WIDTH-1:0]   rd_ptr, wr_ptr;
    logic [2:0]             taken, hs;
    logic                   empty, full, commit, clr_ovf, push, pop;
    logic                   unused_bits;

    function automatic logic [PTR_WIDTH-1:0] ptr_inc(input logic [PTR_WIDTH-1:0] p);
        return (p == PTR_WIDTH'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign empty    = (level == '0);
    assign full     = (level == LEVEL_WIDTH'(DEPTH));
    assign commit   = wr_en && (wr_offset == 2'(REG_COMMIT));
    assign clr_ovf  = wr_en && (wr_offset == 2'(REG_STATUS)) && wr_data[0];
    assign ch_valid = {3{!empty}} & ~taken;
    assign hs       = ch_valid & ch_ready;
    // Retire once every channel has accepted, whether earlier or on this edge.
    assign pop      = !empty && (&(taken | hs));
    assign push     = commit && !full;

    assign head     = mem[rd_ptr];
    assign head_sel = SELECT_WIDTH'(head.sel);
    assign head_typ = TYPE_WIDTH'(head.typ);

    assign unused_bits = ^{wr_data, head};

    always_ff @(posedge clk) begin
        if (rst) begin
            shadow_sel <= '0;
            shadow_typ <= '0;
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            level      <= '0;
            taken      <= '0;
            overflow   <= 1'b0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (wr_en && (wr_offset == 2'(REG_SELECT))) shadow_sel <= wr_data[SELECT_WIDTH-1:0];
            if (wr_en && (wr_offset == 2'(REG_TYPE)))   shadow_typ <= wr_data[TYPE_WIDTH-1:0];

            if (push) begin
                mem[wr_ptr] <= '{sel: MAX_SELECT_WIDTH'(shadow_sel), typ: MAX_TYPE_WIDTH'(shadow_typ)};
                wr_ptr      <= ptr_inc(wr_ptr);
            end

            if (pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
                taken  <= '0;
            end else begin
                taken  <= taken | hs;
            end

            case ({push, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase

            if (commit && full) overflow <= 1'b1;
            else if (clr_ovf)   overflow <= 1'b0;
        end
    end

endmodule

// File: rtl/stream_config_queue.sv
// Per-stream queued reconfiguration block: config address decode and the
// registered read mux around one stream_config_slot per stream.
module stream_config_queue
    import stream_config_pkg::*;
#(
    parameter int unsigned NUM_STREAMS = 2,
    parameter int unsigned NUM_SELECT  = 4,
    parameter int unsigned TYPE_WIDTH  = 4,
    parameter int unsigned DEPTH       = 4,
    parameter int unsigned ADDR_WIDTH  = 8,
    parameter int unsigned DATA_WIDTH  = 32
) (
    input  logic               clk,
    input  logic               rst,
    stream_config_queue_if.slave bus
);
    localparam int unsigned SELECT_WIDTH = calc_select_width(NUM_SELECT);
    localparam int unsigned LEVEL_WIDTH  = $clog2(DEPTH + 1);

    logic [SELECT_WIDTH-1:0] sh_sel   [NUM_STREAMS];
    logic [TYPE_WIDTH-1:0]   sh_typ   [NUM_STREAMS];
    logic [LEVEL_WIDTH-1:0]  lvl      [NUM_STREAMS];
    logic                    ovf      [NUM_STREAMS];
    logic [2:0]              vld      [NUM_STREAMS];
    logic [SELECT_WIDTH-1:0] hd_sel   [NUM_STREAMS];
    logic [TYPE_WIDTH-1:0]   hd_typ   [NUM_STREAMS];
    logic [NUM_STREAMS-1:0]  slot_wr;
    logic [ADDR_WIDTH-1:0]   stream_idx;
    logic [1:0]              offset;
    logic [DATA_WIDTH-1:0]   rd_next;

    // Out-of-range addresses match no slot, so they are ignored on write and read as 0.
    assign stream_idx = bus.cfg_addr >> 2;
    assign offset     = bus.cfg_addr[1:0];

    for (genvar g = 0; g < NUM_STREAMS; g++) begin : g_slot
        assign slot_wr[g] = bus.cfg_wr_en && (stream_idx == ADDR_WIDTH'(g));

        stream_config_slot #(
            .SELECT_WIDTH (SELECT_WIDTH),
            .TYPE_WIDTH   (TYPE_WIDTH),
            .DEPTH        (DEPTH),
            .DATA_WIDTH   (DATA_WIDTH),
            .LEVEL_WIDTH  (LEVEL_WIDTH)
        ) u_slot (
            .clk        (clk),
            .rst        (rst),
            .wr_en      (slot_wr[g]),
            .wr_offset  (offset),
            .wr_data    (bus.cfg_wr_data),
            .shadow_sel (sh_sel[g]),
            .shadow_typ (sh_typ[g]),
            .level      (lvl[g]),
            .overflow   (ovf[g]),
            .ch_valid   (vld[g]),
            .ch_ready   ({bus.type_ready[g], bus.out_sel_ready[g], bus.in_sel_ready[g]}),
            .head_sel   (hd_sel[g]),
            .head_typ   (hd_typ[g])
        );

        assign bus.in_sel_valid[g]  = vld[g][0];
        assign bus.out_sel_valid[g] = vld[g][1];
        assign bus.type_valid[g]    = vld[g][2];
        assign bus.in_sel_data[g]   = hd_sel[g];
        assign bus.out_sel_data[g]  = hd_sel[g];
        assign bus.type_data[g]     = hd_typ[g];
    end

    always_comb begin
        rd_next = '0;
        for (int unsigned s = 0; s < NUM_STREAMS; s++) begin
            if (stream_idx == ADDR_WIDTH'(s)) begin
                case (offset)
                    2'(REG_SELECT): rd_next = DATA_WIDTH'(sh_sel[s]);
                    2'(REG_TYPE):   rd_next = DATA_WIDTH'(sh_typ[s]);
                    2'(REG_STATUS): rd_next = DATA_WIDTH'({ovf[s], lvl[s]});
                    default:        rd_next = '0;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst)                bus.cfg_rd_data <= '0;
        else if (bus.cfg_rd_en) bus.cfg_rd_data <= rd_next;
    end

endmodule
